spi_bus_arbiter: RTL

//  Shares one byte-level SPI master (start/busy/new_data interface) among NUM_REQ requesters.

---
 rtl/spi_bus_arbiter_pkg.sv | 25 ++
 rtl/spi_bus_arbiter_rr_arbiter.sv | 31 +++
 rtl/spi_bus_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/spi_bus_arbiter_pkg.sv
// Shared definitions for the SPI bus arbiter: FSM state encodings, default chip-select timing
// and the helper that sizes the shared setup/hold/timeout counter.
package spi_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_WAIT_TX = 3'd2,
    ST_XFER    = 3'd3,
    ST_HOLD    = 3'd4
  } state_t;

  localparam int DEF_CS_SETUP = 2;
  localparam int DEF_CS_HOLD  = 2;
  localparam int DEF_TIMEOUT  = 255;

  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/spi_bus_arbiter_rr_arbiter.sv
// Round-robin picker: first asserted request at or after ptr, as one-hot grant plus index.
// Purely combinational; no state, no backpressure.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx,
  output logic               any
);

  int cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (int'(ptr) + i) % NUM_REQ;
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/spi_bus_arbiter.sv
// Shares one byte-level SPI master among NUM_REQ requesters with per-requester cs_n framing;
// all outputs registered, one byte in flight at a time. SPI_ARB_TIMEOUT_EN adds the WAIT_TX timeout.
module spi_bus_arbiter
  import spi_bus_arbiter_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int CS_SETUP = DEF_CS_SETUP,
  parameter int CS_HOLD  = DEF_CS_HOLD,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] tx_data,
  input  logic [NUM_REQ-1:0]   tx_valid,
  input  logic [NUM_REQ-1:0]   tx_last,
  output logic [NUM_REQ-1:0]   tx_ready,
  output logic [7:0]           rx_data,
  output logic [NUM_REQ-1:0]   rx_valid,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   cs_n,
  output logic                 spi_start,
  output logic [7:0]           spi_data_in,
  input  logic                 spi_busy,
  input  logic                 spi_new_data,
  input  logic [7:0]           spi_data_out
`ifdef SPI_ARB_TIMEOUT_EN
  , output logic               timeout
`endif
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = cnt_width(CS_SETUP, CS_HOLD, TIMEOUT);

  state_t               state;
  logic [IW-1:0]        ptr;
  logic [IW-1:0]        gidx;
  logic [CW-1:0]        cnt;
  logic                 last_q;
  logic [NUM_REQ-1:0]   arb_gnt;
  logic [IW-1:0]        arb_idx;
  logic                 arb_any;
  logic                 accept;
  logic                 req_g;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr (
    .req (req),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  assign accept = tx_valid[gidx] && !spi_busy;
  assign req_g  = req[gidx];

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      ptr         <= '0;
      gidx        <= '0;
      cnt         <= '0;
      last_q      <= 1'b0;
      gnt         <= '0;
      cs_n        <= '1;
      tx_ready    <= '0;
      rx_valid    <= '0;
      rx_data     <= '0;
      spi_start   <= 1'b0;
      spi_data_in <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      timeout     <= 1'b0;
`endif
    end else begin
      tx_ready  <= '0;
      rx_valid  <= '0;
      spi_start <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
      timeout   <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (arb_any) begin
            gnt   <= arb_gnt;
            gidx  <= arb_idx;
            cs_n  <= ~arb_gnt;
            cnt   <= '0;
            state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (cnt == CW'(CS_SETUP - 1)) begin
            cnt   <= '0;
            state <= ST_WAIT_TX;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_WAIT_TX: begin
          // A presented byte wins over a dropped req so nothing offered is lost.
          if (accept) begin
            tx_ready    <= gnt;
            spi_start   <= 1'b1;
            spi_data_in <= tx_data[8*gidx +: 8];
            last_q      <= tx_last[gidx];
            cnt         <= '0;
            state       <= ST_XFER;
          end else if (!req_g) begin
            cnt   <= '0;
            state <= ST_HOLD;
          end
`ifdef SPI_ARB_TIMEOUT_EN
          else if (cnt == CW'(TIMEOUT - 1)) begin
            cnt     <= '0;
            timeout <= 1'b1;
            state   <= ST_HOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        ST_XFER: begin
          if (spi_new_data) begin
            rx_data  <= spi_data_out;
            rx_valid <= gnt;
            cnt      <= '0;
            state    <= (last_q || !req_g) ? ST_HOLD : ST_WAIT_TX;
          end
        end
        ST_HOLD: begin
          if (cnt == CW'(CS_HOLD - 1)) begin
            gnt   <= '0;
            cs_n  <= '1;
            ptr   <= (gidx == IW'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
